// File: rtl/multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main controller for a multicycle MIPS datapath. It walks the shared
// ALU / memory / register-file datapath through FETCH, DECODE, and the
// per-class execute and writeback states. The control word is decoded from
// the current state. The exceptions are IRWrite/PCWrite in FETCH and the
// completion and timeout pulses, which also depend on mem_ready.
//
// Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100,
// addi 001000. When the MCFSM_JUMP_EN macro is defined, j 000010 is also
// accepted and executes through the JUMP state. Otherwise j is treated as
// an illegal opcode.
//
// Parameters
//   WAIT_W        width of the memory wait counter
//   MEM_WAIT_MAX  wait cycles allowed per memory access before giving up;
//                 0 disables the timeout (must be < 2**WAIT_W)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   opcode       IR[31:26], sampled only in DECODE
//   mem_ready    memory completes the current access this cycle
//   PCWrite .. PCSource   datapath control word
//   state        current state encoding (debug)
//   instr_done   1-cycle pulse on the final cycle of each completed instruction
//   illegal_op   1-cycle pulse in DECODE for an unsupported opcode
//   mem_timeout  1-cycle pulse when a memory wait expires
// ----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int WAIT_W       = 8,
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        EXEC    = 4'd7,
        RWB     = 4'd8,
        BRANCH  = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        JUMP    = 4'd12
    } stateT;

    stateT             curState;
    stateT             nextState;
    logic [5:0]        opQ;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitCntNext;
    logic              waitExpired;
    logic              inWaitState;

    assign state = curState;

    // FETCH, MEMRD and MEMWR are the only states that can stall on memory.
    assign inWaitState = (curState == FETCH) || (curState == MEMRD) || (curState == MEMWR);

    // The wait budget is used up when the counter has reached the limit and
    // memory still has not answered. A ready in the same cycle always takes
    // priority over the timeout.
    assign waitExpired = (MEM_WAIT_MAX != 0) && inWaitState && !mem_ready
                         && (waitCnt == WAIT_W'(MEM_WAIT_MAX));

    // State, wait counter and latched opcode. MEMADR chooses between lw and
    // sw from opQ, so later changes on the opcode bus have no effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curState <= IDLE;
            waitCnt  <= '0;
            opQ      <= '0;
        end else begin
            curState <= nextState;
            waitCnt  <= waitCntNext;
            if (curState == DECODE) begin
                opQ <= opcode;
            end
        end
    end

    // Next-state and control-word decode. Every output defaults to zero, so
    // each state lists only the signals it asserts. IDLE asserts nothing,
    // which keeps the whole word at zero while reset is held.
    always_comb begin
        nextState   = curState;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;

        case (curState)
            IDLE: begin
                nextState = FETCH;
            end
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    nextState = DECODE;
                end else if (waitExpired) begin
                    mem_timeout = 1'b1;
                    nextState   = FETCH;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_R:         nextState = EXEC;
                    OP_BEQ:       nextState = BRANCH;
                    OP_ADDI:      nextState = ADDIEX;
`ifdef MCFSM_JUMP_EN
                    OP_J:         nextState = JUMP;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        nextState  = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nextState = (opQ == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    nextState = MEMWB;
                end else if (waitExpired) begin
                    mem_timeout = 1'b1;
                    nextState   = FETCH;
                end
            end
            MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                nextState  = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nextState  = FETCH;
                end else if (waitExpired) begin
                    mem_timeout = 1'b1;
                    nextState   = FETCH;
                end
            end
            EXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                nextState = RWB;
            end
            RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                nextState  = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                nextState   = FETCH;
            end
            ADDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nextState = ADDIWB;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nextState  = FETCH;
            end
`ifdef MCFSM_JUMP_EN
            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                nextState  = FETCH;
            end
`endif
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Wait counter update. Any state change, and a timeout restart of FETCH,
    // begins a fresh access with the count at zero. A stalled cycle adds one,
    // and the count saturates at its maximum instead of wrapping.
    always_comb begin
        waitCntNext = waitCnt;
        if ((nextState != curState) || mem_timeout) begin
            waitCntNext = '0;
        end else if (inWaitState && !mem_ready && (waitCnt != '1)) begin
            waitCntNext = waitCnt + WAIT_W'(1);
        end
    end

endmodule
